// File: rtl/pixel_stream_gen.sv
// D5M-style pixel stream source: programmable blanking, X/Y counters and
// four selectable test patterns, every output registered.
module pixel_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 0,
  parameter int V_BLANK  = 19000,
  parameter int FV_LEAD  = 1000
) (
  input  logic        D5M_PXCLK,
  input  logic        iRST_N,
  input  logic        iEN,
  input  logic [1:0]  iPATTERN,
  input  logic [11:0] iCONST,
  output logic [11:0] oDATA,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic        oFVAL,
  output logic        oDATA_VAL,
  output logic        oFRAME_DONE,
  output logic [15:0] oFRAME_CNT
);

  // Zero-length phases collapse to a single cycle rather than wrapping the counter.
  localparam logic [15:0] VB_LAST = 16'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  localparam logic [15:0] FL_LAST = 16'((FV_LEAD > 0) ? FV_LEAD - 1 : 0);
  localparam logic [15:0] HB_LAST = 16'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);

  typedef enum logic [2:0] {S_IDLE, S_VBLANK, S_LEAD, S_ACTIVE, S_HBLANK} state_e;

  state_e      state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [1:0]  pat_q, pat_d;
  logic [11:0] cst_q, cst_d;
  logic [3:0]  c16_q, c16_d;
  logic [4:0]  c18_q, c18_d, c20_q, c20_d;
  logic [11:0] data_q, data_d;
  logic        fval_q, fval_d, dval_q, dval_d, done_q, done_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 16'd1;
    x_d     = x_q;
    y_d     = y_q;
    pat_d   = pat_q;
    cst_d   = cst_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    // Ladder wrap counters track the index of the pixel currently on the bus.
    c16_d   = c16_q;
    c18_d   = c18_q;
    c20_d   = c20_q;
    if (state_q == S_ACTIVE) begin
      c16_d = (c16_q == 4'd15) ? 4'd0 : c16_q + 4'd1;
      c18_d = (c18_q == 5'd17) ? 5'd0 : c18_q + 5'd1;
      c20_d = (c20_q == 5'd19) ? 5'd0 : c20_q + 5'd1;
    end
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (iEN) state_d = S_VBLANK;
      end
      S_VBLANK: begin
        if (phase_q == VB_LAST) begin
          phase_d = '0;
          if (iEN) begin
            state_d = S_LEAD;
            pat_d   = iPATTERN;
            cst_d   = iCONST;
            c16_d   = '0;
            c18_d   = '0;
            c20_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LEAD: begin
        if (phase_q == FL_LAST) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_ACTIVE: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            state_d = S_VBLANK;
            phase_d = '0;
            y_d     = '0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 16'd1;
          end else if (H_BLANK > 0) begin
            state_d = S_HBLANK;
            phase_d = '0;
          end else begin
            y_d = y_q + 16'd1;
          end
        end else begin
          x_d = x_q + 16'd1;
        end
      end
      S_HBLANK: begin
        if (phase_q == HB_LAST) begin
          state_d = S_ACTIVE;
          y_d     = y_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they line up with the state register.
  always_comb begin
    fval_d = (state_d == S_LEAD) || (state_d == S_ACTIVE) || (state_d == S_HBLANK);
    dval_d = (state_d == S_ACTIVE);
    data_d = '0;
    if (dval_d) begin
      case (pat_q)
        2'd0:    data_d = cst_q;
        2'd1:    data_d = x_d[11:0];
        2'd2:    data_d = (c16_d == 4'd0) ? 12'd67  :
                          (c18_d == 5'd0) ? 12'd197 :
                          (c20_d == 5'd0) ? 12'd100 : 12'd82;
        default: data_d = (x_d[3] ^ y_d[3]) ? 12'hFFF : 12'h000;
      endcase
    end
  end

  always_ff @(posedge D5M_PXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pat_q   <= '0;
      cst_q   <= '0;
      c16_q   <= '0;
      c18_q   <= '0;
      c20_q   <= '0;
      data_q  <= '0;
      fval_q  <= 1'b0;
      dval_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pat_q   <= pat_d;
      cst_q   <= cst_d;
      c16_q   <= c16_d;
      c18_q   <= c18_d;
      c20_q   <= c20_d;
      data_q  <= data_d;
      fval_q  <= fval_d;
      dval_q  <= dval_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oDATA       = data_q;
  assign oX_Cont     = x_q;
  assign oY_Cont     = y_q;
  assign oFVAL       = fval_q;
  assign oDATA_VAL   = dval_q;
  assign oFRAME_DONE = done_q;
  assign oFRAME_CNT  = cnt_q;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Bench for pixel_stream_gen: two instances (back-to-back lines and with
// horizontal blanking) checked every cycle against a frame-timing model.
module tb_pixel_stream_gen;

  localparam int AHA = 40, AVA = 20, AHB = 0, AVB = 50, AFL = 10;
  localparam int BHA = 24, BVA = 12, BHB = 8, BVB = 30, BFL = 7;
  localparam int HA [2] = '{AHA, BHA};
  localparam int VA [2] = '{AVA, BVA};
  localparam int HB [2] = '{AHB, BHB};
  localparam int VB [2] = '{AVB, BVB};
  localparam int FL [2] = '{AFL, BFL};
  localparam int PER_A = AVB + AFL + AVA * (AHA + AHB) - AHB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pat = 2'd0;
  logic [11:0] cst = 12'd0;

  logic        fv [2], dv [2], dn [2];
  logic [15:0] xx [2], yy [2], cc [2];
  logic [11:0] dd [2];

  always #5 clk = ~clk;

  pixel_stream_gen #(.H_ACTIVE(AHA), .V_ACTIVE(AVA), .H_BLANK(AHB), .V_BLANK(AVB), .FV_LEAD(AFL)) dut_a (
    .D5M_PXCLK(clk), .iRST_N(rst_n), .iEN(en), .iPATTERN(pat), .iCONST(cst),
    .oDATA(dd[0]), .oX_Cont(xx[0]), .oY_Cont(yy[0]), .oFVAL(fv[0]), .oDATA_VAL(dv[0]),
    .oFRAME_DONE(dn[0]), .oFRAME_CNT(cc[0]));

  pixel_stream_gen #(.H_ACTIVE(BHA), .V_ACTIVE(BVA), .H_BLANK(BHB), .V_BLANK(BVB), .FV_LEAD(BFL)) dut_b (
    .D5M_PXCLK(clk), .iRST_N(rst_n), .iEN(en), .iPATTERN(pat), .iCONST(cst),
    .oDATA(dd[1]), .oX_Cont(xx[1]), .oY_Cont(yy[1]), .oFVAL(fv[1]), .oDATA_VAL(dv[1]),
    .oFRAME_DONE(dn[1]), .oFRAME_CNT(cc[1]));

  int vec = 0, errs = 0, cycn = 0;
  int dvc = 0, ndone0 = 0;
  int rise [$];
  int dvq [$];
  logic fv0_prev = 1'b0;

  // Model: t counts cycles since VBLANK entry; the frame layout is pure arithmetic on t.
  bit          m_idle [2];
  int          m_t    [2];
  bit          m_done [2];
  logic [15:0] m_cnt  [2];
  logic [1:0]  m_pat  [2];
  logic [11:0] m_cst  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idle[k] = 1'b1; m_t[k] = 0; m_done[k] = 1'b0;
      m_cnt[k] = '0; m_pat[k] = '0; m_cst[k] = '0;
    end
  endtask

  task automatic step(input int k);
    int per;
    per = VB[k] + FL[k] + VA[k] * (HA[k] + HB[k]) - HB[k];
    m_done[k] = 1'b0;
    if (m_idle[k]) begin
      if (en) begin m_idle[k] = 1'b0; m_t[k] = 0; end
    end else if (m_t[k] == VB[k] - 1) begin
      if (en) begin m_t[k] = VB[k]; m_pat[k] = pat; m_cst[k] = cst; end
      else begin m_idle[k] = 1'b1; m_t[k] = 0; end
    end else if (m_t[k] == per - 1) begin
      m_t[k] = 0; m_done[k] = 1'b1; m_cnt[k] = m_cnt[k] + 16'd1;
    end else begin
      m_t[k] = m_t[k] + 1;
    end
  endtask

  function automatic logic [62:0] exp_v(input int k);
    logic fvl, dvl;
    logic [15:0] x, y;
    logic [11:0] d;
    int p, l, col, n;
    fvl = 1'b0; dvl = 1'b0; x = '0; y = '0; d = '0;
    if (!m_idle[k] && m_t[k] >= VB[k]) begin
      fvl = 1'b1;
      p = m_t[k] - VB[k] - FL[k];
      l = HA[k] + HB[k];
      if (p >= 0) begin
        y = 16'(p / l);
        col = p % l;
        if (col < HA[k]) begin
          dvl = 1'b1;
          x = 16'(col);
          n = (p / l) * HA[k] + col;
          case (m_pat[k])
            2'd0:    d = m_cst[k];
            2'd1:    d = x[11:0];
            2'd2:    d = (n % 16 == 0) ? 12'd67 : (n % 18 == 0) ? 12'd197 :
                         (n % 20 == 0) ? 12'd100 : 12'd82;
            default: d = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
          endcase
        end
      end
    end
    return {fvl, dvl, m_done[k], x, y, d, m_cnt[k]};
  endfunction

  function automatic logic [62:0] obs_v(input int k);
    return {fv[k], dv[k], dn[k], xx[k], yy[k], dd[k], cc[k]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vec++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h (t=%0t)", tag, o, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin step(0); step(1); end
    #1;
    cycn++;
    chk("cyc_a {fv,dv,done,x,y,data,cnt}", obs_v(0), exp_v(0));
    chk("cyc_b {fv,dv,done,x,y,data,cnt}", obs_v(1), exp_v(1));
    if (fv[0] && !fv0_prev) rise.push_back(cycn);
    fv0_prev = fv[0];
    if (dv[0]) dvc++;
    if (dn[0]) begin dvq.push_back(dvc); dvc = 0; ndone0++; end
  endtask

  task automatic wait_done(input int k);
    int i = 0;
    do begin cyc(); i++; end while (!dn[k] && i < 3000);
    chk("wait_done_timeout", dn[k], 1);
  endtask

  task automatic wait_pix(input int k, input int x, input int y);
    int i = 0;
    bit found = 1'b0;
    while (!found && i < 3000) begin
      cyc(); i++;
      found = dv[k] && (xx[k] == 16'(x)) && (yy[k] == 16'(y));
    end
    chk("wait_pix_timeout", found, 1);
  endtask

  task automatic check_at(input int x, input int y, input int e, input string tag);
    wait_pix(0, x, y);
    chk(tag, dd[0], e);
  endtask

  initial begin
    int c0, nb, cv;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", obs_v(0), 0);
    chk("reset_b", obs_v(1), 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Constant pattern, full frame timing on instance A.
    en = 1'b1; pat = 2'd0; cst = 12'd47;
    c0 = cycn;
    wait_done(0);
    chk("frame_cnt_1", cc[0], 1);
    chk("dval_count", (dvq.size() > 0) ? dvq[0] : -1, AHA * AVA);
    chk("fval_rise_after_vblank", (rise.size() > 0) ? rise[0] - (c0 + 1) : -1, AVB);
    begin
      int i = 0;
      while (rise.size() < 2 && i < 3000) begin cyc(); i++; end
    end
    chk("frame_period", (rise.size() > 1) ? rise[1] - rise[0] : -1, PER_A);

    // Ramp from the following frame.
    pat = 2'd1;
    wait_done(0);
    check_at(5, 3, 5, "ramp_5_3");
    check_at(AHA - 1, AVA - 1, AHA - 1, "ramp_last");

    // Ladder, two consecutive frames.
    pat = 2'd2;
    check_at(0, 0, 67, "lad_n0");
    check_at(1, 0, 82, "lad_n1");
    check_at(18, 0, 197, "lad_n18");
    check_at(20, 0, 100, "lad_n20");
    check_at(24, 3, 67, "lad_n144");
    check_at(20, 4, 197, "lad_n180");
    check_at(0, 0, 67, "lad_restart_n0");
    check_at(1, 0, 82, "lad_restart_n1");

    // Pattern switched mid-frame only affects the next frame.
    cv = int'($urandom_range(0, 4095));
    pat = 2'd0; cst = 12'(cv);
    wait_done(0);
    wait_pix(0, 0, 5);
    pat = 2'd3;
    check_at(3, 10, cv, "const_held");
    check_at(8, 0, 12'hFFF, "checker_8_0");
    check_at(8, 8, 12'h000, "checker_8_8");

    // Enable dropped mid-frame: frame completes, then idle.
    wait_pix(0, 0, 10);
    en = 1'b0;
    wait_done(0);
    repeat (AVB + 5) cyc();
    chk("idle_fval", fv[0], 0);
    nb = ndone0;
    repeat (1000) cyc();
    chk("idle_no_frames", ndone0 - nb, 0);
    en = 1'b1;
    wait_done(0);

    // Randomized pattern/constant churn.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ($urandom_range(0, 199) == 0) pat = 2'($urandom);
      if ($urandom_range(0, 99) == 0) cst = 12'($urandom);
    end

    // Asynchronous reset mid-frame.
    wait_pix(0, 0, 8);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_a", obs_v(0), 0);
    chk("async_rst_b", obs_v(1), 0);
    repeat (2) cyc();
    rise.delete();
    rst_n = 1'b1;
    c0 = cycn;
    wait_done(0);
    chk("cnt_after_rst", cc[0], 1);
    chk("fval_rise_after_rst", (rise.size() > 0) ? rise[0] - (c0 + 1) : -1, AVB);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
